// File: rtl/demux1to4_8_pack_if.sv
// Byte-lane stream in, packed word stream out, for the demux1to4_8_pack block.
// The slave modport is the packer's view; master is the view of whoever drives it.
interface demux1to4_8_pack_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [4*W-1:0] out_word;
    logic [3:0]     out_mask;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_mask
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_word, out_mask
    );
endinterface

// File: rtl/demux1to4_8_pack.sv
// Steers tagged bytes into four lane registers and presents the packed word
// with a lane-written mask once all lanes are filled or a last byte arrives.
//
// state | meaning
// FILL  | accepting bytes into lanes, in_ready high
// HOLD  | word complete and presented, waiting for downstream drain
module demux1to4_8_pack #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux1to4_8_pack_if.slave   bus
);
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t         state;
    logic [4*W-1:0] word;
    logic [3:0]     mask;
    logic [3:0]     sel_bit;

    assign sel_bit = 4'b0001 << bus.in_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            word  <= '0;
            mask  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < 4; k++) begin
                            if (sel_bit[k]) word[k*W +: W] <= bus.in_data;
                        end
                        mask <= mask | sel_bit;
                        // Rewriting a lane leaves the mask unchanged, so it cannot complete a word alone.
                        if (bus.in_last || ((mask | sel_bit) == 4'hF)) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        word  <= '0;
                        mask  <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_word  = word;
    assign bus.out_mask  = mask;
endmodule

// File: tb/tb_demux1to4_8_pack.sv
// Scoreboard bench for demux1to4_8_pack: a word-level model queues expected words,
// a negedge monitor compares whatever the packer presents.
module tb_demux1to4_8_pack;
    localparam int W = 8;

    typedef struct packed {
        logic [4*W-1:0] word;
        logic [3:0]     mask;
    } exp_t;

    logic clk;
    logic rst;

    demux1to4_8_pack_if #(.W(W)) bus();

    demux1to4_8_pack #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    logic [W-1:0] m_lane[4];
    logic [3:0]  m_mask;
    bit          m_hold;
    int          acc_cnt;
    int          checks;
    int          failures;
    bit          chk_en;
    int          ready_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Reference model: a word is a set of lane bytes; it closes when every lane
    // has been written or a last byte arrives, and is released by a drain.
    initial begin
        m_hold  = 1'b0;
        m_mask  = '0;
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) m_lane[k] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_hold = 1'b0;
                m_mask = '0;
                for (int k = 0; k < 4; k++) m_lane[k] = '0;
                q.delete();
            end else if (!m_hold) begin
                if (bus.in_valid) begin
                    exp_t e;
                    m_lane[bus.in_sel] = bus.in_data;
                    m_mask[bus.in_sel] = 1'b1;
                    acc_cnt++;
                    if (bus.in_last || m_mask == 4'hF) begin
                        e.word = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
                        e.mask = m_mask;
                        q.push_back(e);
                        m_hold = 1'b1;
                    end
                end
            end else if (bus.out_ready) begin
                m_hold = 1'b0;
                m_mask = '0;
                for (int k = 0; k < 4; k++) m_lane[k] = '0;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready", bus.in_ready, !m_hold);
                check("out_valid", bus.out_valid, m_hold);
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_word unexpected got=0x%0h exp=none", bus.out_word);
                    end else begin
                        check("out_word", bus.out_word, q[0].word);
                        check("out_mask", bus.out_mask, q[0].mask);
                        if (bus.out_ready && !rst) void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, other = stalled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [1:0] sel, input logic [W-1:0] data, input logic last);
        int start;
        bit done;
        start = acc_cnt;
        done  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) done = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("accept", done, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'($urandom_range(3));
        bus.in_data  = W'($urandom);
        bus.in_last  = 1'($urandom_range(1));
        repeat (n) @(posedge clk);
        #1;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        chk_en       = 1'b0;
        ready_mode   = 2;
        bus.out_ready = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 8'h5A;
        bus.in_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk_en       = 1'b1;
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_mask", bus.out_mask, 0);
        check("reset out_word", bus.out_word, 0);
        check("reset in_ready", bus.in_ready, 1);

        // full word, out of order
        ready_mode = 0;
        send(2'd2, 8'hCC, 1'b0);
        send(2'd0, 8'hAA, 1'b0);
        send(2'd3, 8'hDD, 1'b0);
        send(2'd1, 8'hBB, 1'b0);
        idle(3);

        // partial word
        send(2'd1, 8'h11, 1'b0);
        send(2'd3, 8'h33, 1'b1);
        idle(3);

        // overwrite
        send(2'd0, 8'h01, 1'b0);
        send(2'd0, 8'h02, 1'b0);
        send(2'd1, 8'h03, 1'b0);
        send(2'd2, 8'h04, 1'b0);
        send(2'd3, 8'h05, 1'b0);
        idle(3);

        // backpressure with a byte waiting upstream
        ready_mode = 2;
        send(2'd0, 8'h10, 1'b0);
        send(2'd1, 8'h20, 1'b0);
        send(2'd2, 8'h30, 1'b0);
        send(2'd3, 8'h40, 1'b0);
        fork
            send(2'd0, 8'hEE, 1'b1);
            begin
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
        join
        idle(3);

        // reset while the word is being drained
        ready_mode = 2;
        send(2'd3, 8'h9A, 1'b0);
        send(2'd2, 8'h9B, 1'b0);
        send(2'd1, 8'h9C, 1'b0);
        send(2'd0, 8'h9D, 1'b0);
        rst        = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("hold reset out_valid", bus.out_valid, 0);
        check("hold reset out_mask", bus.out_mask, 0);
        check("hold reset out_word", bus.out_word, 0);
        send(2'd2, 8'h77, 1'b1);
        idle(3);

        // randomized traffic with random backpressure
        ready_mode = 1;
        repeat (300) begin
            if ($urandom_range(3) == 0) idle(1);
            else send(2'($urandom_range(3)), W'($urandom), 1'($urandom_range(5) == 0));
        end
        bus.in_valid = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 100 && (m_hold || q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("final drained", m_hold, 0);
        check("final queue empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
